// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction array, MSB byte first.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a per-session XOR checksum output (csum).
module imem_loader #(
   parameter int MEM_BYTES = 20,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [31:0]       word_in,
   input  logic              word_valid,
   input  logic              word_last,
   output logic              word_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]       csum
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_WR0, S_WR1, S_WR2, S_WR3, S_FIN
   } state_t;

   localparam logic [ADDR_W:0] LAST_BYTE = (ADDR_W+1)'(MEM_BYTES - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       word_q, word_d;
   logic              last_q, last_d;
   logic              err_q, err_d;
   logic [ADDR_W:0]   end_addr;
   logic              in_range;
   logic [31:0]       word_rot;

   // One extra bit so a base near the top of the address space cannot wrap into range.
   assign end_addr = {1'b0, addr_q} + (ADDR_W+1)'(3);
   assign in_range = (end_addr <= LAST_BYTE);
   assign word_rot = {word_q[23:0], word_q[31:24]};

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;
   assign csum = csum_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      word_q <= word_d;
      last_q <= last_d;
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      word_d     = word_q;
      last_d     = last_q;
      err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      word_ready = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      done       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = '0;
`endif
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            word_ready = 1'b1;
            if (word_valid) begin
               word_d = word_in;
               last_d = word_last;
               if (in_range) begin
                  state_d = S_WR0;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_FIN;
               end
            end
         end
         // The shift register rotates so the next byte is always in [31:24].
         S_WR0: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = word_q[31:24];
            word_d    = word_rot;
            state_d   = S_WR1;
         end
         S_WR1: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q + ADDR_W'(1);
            mem_wdata = word_q[31:24];
            word_d    = word_rot;
            state_d   = S_WR2;
         end
         S_WR2: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q + ADDR_W'(2);
            mem_wdata = word_q[31:24];
            word_d    = word_rot;
            state_d   = S_WR3;
         end
         S_WR3: begin
            mem_we    = 1'b1;
            mem_addr  = addr_q + ADDR_W'(3);
            mem_wdata = word_q[31:24];
            word_d    = word_rot;
            addr_d    = addr_q + ADDR_W'(4);
`ifdef IMEM_LOADER_CHECKSUM_EN
            // After three rotations, one more restores the original word.
            csum_d    = csum_q ^ word_rot;
`endif
            state_d   = last_q ? S_FIN : S_WAIT;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign err  = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-level write-list model.
module tb_imem_loader;

   localparam int MEM_BYTES = 20;
   localparam int ADDR_W    = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [31:0]       word_in;
   logic              word_valid;
   logic              word_last;
   logic              word_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
   logic              err;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]       csum;
`endif

   always #5 clk = ~clk;

   imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_last  (word_last),
      .word_ready (word_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .csum       (csum)
`endif
   );

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   bit mon_en = 1'b0;

   int          wcyc[$];
   logic [31:0] waddr[$];
   logic [7:0]  wdat[$];
   int          hcyc[$];
   int          dcyc[$];
   logic [31:0] wbuf[8];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_we) begin
            wcyc.push_back(cyc);
            waddr.push_back(mem_addr);
            wdat.push_back(mem_wdata);
         end else begin
            chk("bus_quiet", 64'({mem_addr, mem_wdata}), 64'd0);
         end
         if (word_valid && word_ready) hcyc.push_back(cyc);
         if (done) dcyc.push_back(cyc);
      end
   end

   task automatic clear_mon();
      wcyc.delete(); waddr.delete(); wdat.delete(); hcyc.delete(); dcyc.delete();
   endtask

   // Model: word i goes to base+4i unless its last byte falls outside the array,
   // in which case that word is dropped, err is raised and the session ends.
   task automatic session(input logic [31:0] base, input int n, input int gap_max, input bit pre);
      logic [31:0] ea[$];
      logic [7:0]  ed[$];
      logic [32:0] a;
      logic [31:0] csum_exp;
      int bad, sent, g, last_h, nw;
      bit hs;
      bad = -1;
      csum_exp = '0;
      for (int i = 0; i < n; i++) begin
         a = {1'b0, base} + 33'(4 * i);
         if (a + 33'd3 > 33'(MEM_BYTES - 1)) begin
            bad = i;
            break;
         end
         for (int k = 0; k < 4; k++) begin
            ea.push_back(a[31:0] + 32'(k));
            ed.push_back(wbuf[i][31 - 8*k -: 8]);
         end
         csum_exp ^= wbuf[i];
      end
      sent = (bad >= 0) ? bad + 1 : n;
      clear_mon();

      @(posedge clk); #1;
      start = 1'b1; base_addr = base;
      word_valid = pre; word_in = wbuf[0]; word_last = (n == 1);
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < sent; i++) begin
         if (!(i == 0 && pre)) begin
            g = $urandom_range(0, gap_max);
            word_valid = 1'b0;
            repeat (g) begin
               start = ($urandom_range(0, 3) == 0); base_addr = $urandom;
               @(posedge clk); #1;
            end
         end
         word_valid = 1'b1; word_in = wbuf[i]; word_last = (i == n - 1);
         hs = 1'b0;
         for (int t = 0; t < 40 && !hs; t++) begin
            start = ($urandom_range(0, 3) == 0); base_addr = $urandom;
            @(negedge clk);
            hs = word_ready;
            @(posedge clk); #1;
         end
         start = 1'b0;
         word_valid = 1'b0;
         if (!hs) begin
            chk("hs_timeout", 64'd0, 64'd1);
            break;
         end
      end
      word_valid = 1'b0; start = 1'b0;
      repeat (8) @(posedge clk);
      #1;

      chk("n_handshakes", 64'(hcyc.size()), 64'(sent));
      chk("n_writes", 64'(wcyc.size()), 64'(ea.size()));
      nw = (wcyc.size() < ea.size()) ? wcyc.size() : ea.size();
      for (int k = 0; k < nw; k++) begin
         chk("wr_addr", 64'(waddr[k]), 64'(ea[k]));
         chk("wr_data", 64'(wdat[k]), 64'(ed[k]));
         if (k / 4 < hcyc.size())
            chk("wr_cycle", 64'(wcyc[k]), 64'(hcyc[k/4] + 1 + k % 4));
      end
      for (int i = 1; i < hcyc.size(); i++) begin
         if (gap_max == 0) chk("hs_spacing", 64'(hcyc[i] - hcyc[i-1]), 64'd5);
         else              chk("hs_spacing_min", 64'(hcyc[i] - hcyc[i-1] >= 5), 64'd1);
      end
      chk("n_done", 64'(dcyc.size()), 64'd1);
      if (dcyc.size() >= 1 && hcyc.size() >= 1) begin
         last_h = hcyc[hcyc.size() - 1];
         chk("done_cycle", 64'(dcyc[0]), 64'(last_h + ((bad >= 0) ? 1 : 5)));
      end
      chk("err_flag", 64'(err), 64'(bad >= 0));
      chk("busy_end", 64'(busy), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("csum", 64'(csum), 64'(csum_exp));
`endif
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = '0;
      word_in = '0; word_valid = 1'b0; word_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(word_ready), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_bus", 64'({mem_addr, mem_wdata}), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("rst_csum", 64'(csum), 64'd0);
`endif
      reset = 1'b0;
      mon_en = 1'b1;

      // word_valid while idle must not be consumed
      word_valid = 1'b1; word_in = 32'hDEADBEEF; word_last = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      word_valid = 1'b0;
      chk("idle_hs", 64'(hcyc.size()), 64'd0);
      chk("idle_writes", 64'(wcyc.size()), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      wbuf[0] = 32'h8C02000E;
      session(32'd0, 1, 0, 1'b0);

      wbuf[0] = 32'h8C02000E; wbuf[1] = 32'h11290002; wbuf[2] = 32'h00623020;
      wbuf[3] = 32'h00C23822; wbuf[4] = 32'h01043020;
      session(32'd0, 5, 0, 1'b0);

      wbuf[0] = $urandom; wbuf[1] = $urandom;
      session(32'd16, 2, 0, 1'b1);
      session(32'hFFFFFFFE, 2, 0, 1'b0);
      session(32'(MEM_BYTES - 4), 1, 2, 1'b0);

      // Reset while the second byte is being written
      clear_mon();
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'd4;
      @(posedge clk); #1;
      start = 1'b0; word_valid = 1'b1; word_in = $urandom; word_last = 1'b1;
      @(negedge clk);
      chk("rmw_ready", 64'(word_ready), 64'd1);
      @(posedge clk); #1;
      word_valid = 1'b0;
      @(posedge clk); #1;
      chk("rmw_wr1_addr", 64'(mem_addr), 64'd5);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rmw_we", 64'(mem_we), 64'd0);
      chk("rmw_busy", 64'(busy), 64'd0);
      chk("rmw_ready_off", 64'(word_ready), 64'd0);
      chk("rmw_done", 64'(done), 64'd0);
      chk("rmw_bus", 64'({mem_addr, mem_wdata}), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      chk("rmw_writes", 64'(wcyc.size()), 64'd2);
      chk("rmw_no_done", 64'(dcyc.size()), 64'd0);
      wbuf[0] = $urandom; wbuf[1] = $urandom;
      session(32'd0, 2, 1, 1'b0);

      for (int s = 0; s < 40; s++) begin
         int n;
         logic [31:0] b;
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) wbuf[i] = $urandom;
         if ($urandom_range(0, 7) == 0) b = $urandom;
         else                           b = 32'($urandom_range(0, MEM_BYTES + 3));
         session(b, n, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
